seg_scan_display: RTL

Parametrised, time-multiplexed 7-segment display driver for the alarm-clock top level. Takes a packed nibble array from the service blocks and scans it one digit at a time onto a shared segment bus. Adds hex decoding, per-digit blanking, per-digit blinking for edit cursors, and decimal points. Double-buffers the input and commits it only at frame boundaries, so a digit never tears mid-scan.

---
 rtl/seg_pkg.sv | 32 +++
 rtl/seg_hex_decode.sv | 38 +++
 rtl/seg_scan_display.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the scanned 7-segment display path.
//   - NIBBLE_W          : width of one display digit code
//   - SEG_0 .. SEG_F    : active-high segment patterns, bit6..bit0 = g..a
//   - SEG_OFF           : all segments dark
// No ports (package).
// -----------------------------------------------------------------------------
package seg_pkg;

   localparam int NIBBLE_W = 4;

   localparam logic [6:0] SEG_OFF = 7'b0000000;

   localparam logic [6:0] SEG_0 = 7'b0111111;
   localparam logic [6:0] SEG_1 = 7'b0000110;
   localparam logic [6:0] SEG_2 = 7'b1011011;
   localparam logic [6:0] SEG_3 = 7'b1001111;
   localparam logic [6:0] SEG_4 = 7'b1100110;
   localparam logic [6:0] SEG_5 = 7'b1101101;
   localparam logic [6:0] SEG_6 = 7'b1111101;
   localparam logic [6:0] SEG_7 = 7'b0000111;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1101111;
   localparam logic [6:0] SEG_A = 7'b1110111;
   localparam logic [6:0] SEG_B = 7'b1111100;
   localparam logic [6:0] SEG_C = 7'b0111001;
   localparam logic [6:0] SEG_D = 7'b1011110;
   localparam logic [6:0] SEG_E = 7'b1111001;
   localparam logic [6:0] SEG_F = 7'b1110001;

endpackage

// File: rtl/seg_hex_decode.sv
// -----------------------------------------------------------------------------
// seg_hex_decode
// Combinational hex nibble to 7-segment decoder (active-high).
// Ports:
//   nibble  in  4  hex digit 0..F
//   pattern out 7  segments, bit6..bit0 = g..a
// -----------------------------------------------------------------------------
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [NIBBLE_W-1:0] nibble,
   output logic [6:0]          pattern
);

   always_comb begin
      pattern = SEG_OFF;
      case (nibble)
         4'h0: pattern = SEG_0;
         4'h1: pattern = SEG_1;
         4'h2: pattern = SEG_2;
         4'h3: pattern = SEG_3;
         4'h4: pattern = SEG_4;
         4'h5: pattern = SEG_5;
         4'h6: pattern = SEG_6;
         4'h7: pattern = SEG_7;
         4'h8: pattern = SEG_8;
         4'h9: pattern = SEG_9;
         4'hA: pattern = SEG_A;
         4'hB: pattern = SEG_B;
         4'hC: pattern = SEG_C;
         4'hD: pattern = SEG_D;
         4'hE: pattern = SEG_E;
         4'hF: pattern = SEG_F;
         default: pattern = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
// Time-multiplexed 7-segment driver. Inputs are captured into a pending
// buffer on load and committed to the display buffer only at the frame-end
// cycle, so a frame never shows a mix of old and new digits.
//
// Optional feature macro: SEG_BLINK_EN
//   defined     : free-running blink counter and blink_phase gate blink_mask
//   not defined : blink logic removed, blink_mask and BLINK_DIV ignored
//
// Ports:
//   clk         in  1          system clock
//   resetn      in  1          synchronous reset, active-high
//   num         in  4*DIGITS   nibble array, digit i = num[4i+3:4i]
//   dp          in  DIGITS     decimal point request per digit
//   blank_mask  in  DIGITS     1 forces digit dark
//   blink_mask  in  DIGITS     1 makes digit blink
//   load        in  1          capture strobe for num/dp/blank_mask/blink_mask
//   seg         out 7          segments g..a (registered)
//   dp_out      out 1          decimal point of the enabled digit (registered)
//   an          out DIGITS     one-hot digit enable (registered)
//   frame_done  out 1          one-cycle pulse when an switches to digit 0
// -----------------------------------------------------------------------------
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000,
   parameter int ACTIVE_LOW  = 0
)(
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [NIBBLE_W*DIGITS-1:0] num,
   input  logic [DIGITS-1:0]          dp,
   input  logic [DIGITS-1:0]          blank_mask,
   input  logic [DIGITS-1:0]          blink_mask,
   input  logic                       load,
   output logic [6:0]                 seg,
   output logic                       dp_out,
   output logic [DIGITS-1:0]          an,
   output logic                       frame_done
);

   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = $clog2(DIGITS);
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic          INV      = (ACTIVE_LOW != 0);

   logic [RW-1:0]                ref_cnt;
   logic [IW-1:0]                idx;
   logic                         wrap_d;
   logic                         pend_valid;
   logic [NIBBLE_W*DIGITS-1:0]   pend_num, disp_num;
   logic [DIGITS-1:0]            pend_dp, disp_dp;
   logic [DIGITS-1:0]            pend_blank, disp_blank;

   logic                         ref_tc;
   logic                         frame_end;
   logic                         dark;
   logic [NIBBLE_W-1:0]          cur_nibble;
   logic [6:0]                   cur_pattern;
   logic [6:0]                   seg_next;
   logic                         dp_next;
   logic [DIGITS-1:0]            an_next;

   assign ref_tc    = (ref_cnt == REF_LAST);
   assign frame_end = ref_tc && (idx == IDX_LAST);

`ifdef SEG_BLINK_EN
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [BW-1:0]     blink_cnt;
   logic              blink_phase;
   logic [DIGITS-1:0] pend_blink, disp_blink;

   // Blink timing runs on its own and is not tied to the scan.
   always_ff @(posedge clk) begin
      if (resetn) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         pend_blink  <= '0;
         disp_blink  <= '0;
      end else begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
         if (load) pend_blink <= blink_mask;
         if (frame_end) begin
            if (load)            disp_blink <= blink_mask;
            else if (pend_valid) disp_blink <= pend_blink;
         end
      end
   end

   assign dark = disp_blank[idx] | (disp_blink[idx] & blink_phase);
`else
   logic unused_blink_cfg;
   assign unused_blink_cfg = ^{blink_mask, 32'(BLINK_DIV)};
   assign dark = disp_blank[idx];
`endif

   assign cur_nibble = disp_num[idx*NIBBLE_W +: NIBBLE_W];

   seg_hex_decode u_decode (
      .nibble  (cur_nibble),
      .pattern (cur_pattern)
   );

   // A dark digit keeps its anode enabled; only segments and dp go off.
   assign seg_next = dark ? SEG_OFF : cur_pattern;
   assign dp_next  = disp_dp[idx] & ~dark;
   assign an_next  = DIGITS'(1) << idx;

   always_ff @(posedge clk) begin
      if (resetn) begin
         ref_cnt    <= '0;
         idx        <= '0;
         wrap_d     <= 1'b0;
         pend_valid <= 1'b0;
         pend_num   <= '0;
         pend_dp    <= '0;
         pend_blank <= '0;
         disp_num   <= '0;
         disp_dp    <= '0;
         disp_blank <= '0;
         seg        <= {7{INV}};
         dp_out     <= INV;
         an         <= {DIGITS{INV}};
         frame_done <= 1'b0;
      end else begin
         ref_cnt <= ref_tc ? '0 : ref_cnt + 1'b1;
         if (ref_tc) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

         // wrap_d delays the wrap by one cycle so frame_done lines up with
         // the output register that first shows digit 0.
         wrap_d <= frame_end;

         if (load) begin
            pend_num   <= num;
            pend_dp    <= dp;
            pend_blank <= blank_mask;
         end
         // A load landing on the frame-end cycle bypasses pending.
         if (frame_end) begin
            pend_valid <= 1'b0;
            if (load) begin
               disp_num   <= num;
               disp_dp    <= dp;
               disp_blank <= blank_mask;
            end else if (pend_valid) begin
               disp_num   <= pend_num;
               disp_dp    <= pend_dp;
               disp_blank <= pend_blank;
            end
         end else if (load) begin
            pend_valid <= 1'b1;
         end

         seg        <= seg_next ^ {7{INV}};
         dp_out     <= dp_next ^ INV;
         an         <= an_next ^ {DIGITS{INV}};
         frame_done <= wrap_d;
      end
   end

endmodule
